// File: rtl/led_pwm_axi_if.sv
// AXI4 burst slave bundle for the LED PWM block: write address/data/response and read address/data.
// Signals keep their bus names so the slave modport matches the usual AXI slave pinout.
interface led_pwm_axi_if #(
    parameter int ADDR_W = 6
);
    logic [ADDR_W-1:0] s_axi_awaddr;
    logic [7:0]        s_axi_awlen;
    logic              s_axi_awvalid;
    logic              s_axi_awready;
    logic [31:0]       s_axi_wdata;
    logic [3:0]        s_axi_wstrb;
    logic              s_axi_wlast;
    logic              s_axi_wvalid;
    logic              s_axi_wready;
    logic [1:0]        s_axi_bresp;
    logic              s_axi_bvalid;
    logic              s_axi_bready;
    logic [ADDR_W-1:0] s_axi_araddr;
    logic [7:0]        s_axi_arlen;
    logic              s_axi_arvalid;
    logic              s_axi_arready;
    logic [31:0]       s_axi_rdata;
    logic [1:0]        s_axi_rresp;
    logic              s_axi_rlast;
    logic              s_axi_rvalid;
    logic              s_axi_rready;

    modport slave (
        input  s_axi_awaddr, s_axi_awlen, s_axi_awvalid,
        input  s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
        input  s_axi_bready,
        input  s_axi_araddr, s_axi_arlen, s_axi_arvalid,
        input  s_axi_rready,
        output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
        output s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid
    );

    modport master (
        output s_axi_awaddr, s_axi_awlen, s_axi_awvalid,
        output s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
        output s_axi_bready,
        output s_axi_araddr, s_axi_arlen, s_axi_arvalid,
        output s_axi_rready,
        input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
        input  s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid
    );
endinterface

// File: rtl/led_pwm_axi.sv
// Multi-channel LED PWM with an AXI4 INCR burst register port (CTRL, per-channel DUTY).
// Reads return the first beat 1 cycle after AR, writes land 1 cycle after W; rready/bready stalls hold the FSMs.
module led_pwm_axi #(
    parameter int NUM_CH = 8,
    parameter int PWM_W  = 8,
    parameter int ADDR_W = 6
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    led_pwm_axi_if.slave      s_axi,
    output logic [NUM_CH-1:0] led_o
);

    localparam int WA_W = ADDR_W - 2;
    localparam logic [PWM_W-1:0] CNT_MAX = PWM_W'((1 << PWM_W) - 2);

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wstate_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_t;

    // ready outputs stay low until the first clock after reset release
    logic armed;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) armed <= 1'b0;
        else          armed <= 1'b1;
    end

    // ---------------- write channel ----------------
    wstate_t         w_state, w_next;
    logic            awready, wready, bvalid;
    logic            aw_hs, w_hs;
    logic [WA_W-1:0] w_addr;
    logic [7:0]      w_len, w_beat;
    logic            wr_vld;
    logic [WA_W-1:0] wr_idx;
    logic [23:0]     wr_dat;
    logic [2:0]      wr_strb;

    assign aw_hs = s_axi.s_axi_awvalid && awready;
    assign w_hs  = s_axi.s_axi_wvalid && wready;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) w_state <= W_IDLE;
        else          w_state <= w_next;
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_next = W_DATA;
            W_DATA:  if (w_hs && (w_beat == w_len)) w_next = W_RESP;
            W_RESP:  if (s_axi.s_axi_bready) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_comb begin
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        case (w_state)
            W_IDLE:  awready = armed;
            W_DATA:  wready  = 1'b1;
            W_RESP:  bvalid  = 1'b1;
            default: ;
        endcase
    end

    // beat count, not wlast, decides when the burst ends
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            w_addr  <= '0;
            w_len   <= '0;
            w_beat  <= '0;
            wr_vld  <= 1'b0;
            wr_idx  <= '0;
            wr_dat  <= '0;
            wr_strb <= '0;
        end else begin
            if (aw_hs) begin
                w_addr <= s_axi.s_axi_awaddr[ADDR_W-1:2];
                w_len  <= s_axi.s_axi_awlen;
                w_beat <= '0;
            end else if (w_hs) begin
                w_addr <= w_addr + WA_W'(1);
                w_beat <= w_beat + 8'd1;
            end
            wr_vld <= w_hs;
            if (w_hs) begin
                wr_idx  <= w_addr;
                wr_dat  <= s_axi.s_axi_wdata[23:0];
                wr_strb <= s_axi.s_axi_wstrb[2:0];
            end
        end
    end

    // ---------------- register file ----------------
    logic             ctrl_en;
    logic [15:0]      presc;
    logic [PWM_W-1:0] duty_sh  [NUM_CH];
    logic [PWM_W-1:0] duty_act [NUM_CH];
    logic [PWM_W-1:0] duty_mask;

    assign duty_mask = PWM_W'({{8{wr_strb[1]}}, {8{wr_strb[0]}}});

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ctrl_en <= 1'b0;
            presc   <= '0;
            for (int k = 0; k < NUM_CH; k++) duty_sh[k] <= '0;
        end else if (wr_vld) begin
            if (wr_idx == '0) begin
                if (wr_strb[0]) ctrl_en     <= wr_dat[0];
                if (wr_strb[1]) presc[7:0]  <= wr_dat[15:8];
                if (wr_strb[2]) presc[15:8] <= wr_dat[23:16];
            end
            for (int k = 0; k < NUM_CH; k++) begin
                if (wr_idx == WA_W'(k + 2))
                    duty_sh[k] <= (duty_sh[k] & ~duty_mask) | (wr_dat[PWM_W-1:0] & duty_mask);
            end
        end
    end

    // ---------------- read channel ----------------
    rstate_t         r_state, r_next;
    logic            arready, rvalid;
    logic            ar_hs, r_hs;
    logic [WA_W-1:0] r_addr, rd_sel;
    logic [7:0]      r_len, r_beat;
    logic [31:0]     r_dat, rd_mux;
    logic            r_last;

    assign ar_hs = s_axi.s_axi_arvalid && arready;
    assign r_hs  = rvalid && s_axi.s_axi_rready;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) r_state <= R_IDLE;
        else          r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_DATA;
            R_DATA:  if (r_hs && r_last) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_comb begin
        arready = 1'b0;
        rvalid  = 1'b0;
        case (r_state)
            R_IDLE:  arready = armed;
            R_DATA:  rvalid  = 1'b1;
            default: ;
        endcase
    end

    // in IDLE the mux looks at the incoming AR address, in DATA at the next beat
    assign rd_sel = (r_state == R_IDLE) ? s_axi.s_axi_araddr[ADDR_W-1:2] : r_addr + WA_W'(1);

    always_comb begin
        rd_mux = '0;
        if (rd_sel == '0) rd_mux = {8'h00, presc, 7'h00, ctrl_en};
        for (int k = 0; k < NUM_CH; k++) begin
            if (rd_sel == WA_W'(k + 2)) rd_mux = 32'(duty_sh[k]);
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_addr <= '0;
            r_len  <= '0;
            r_beat <= '0;
            r_dat  <= '0;
            r_last <= 1'b0;
        end else if (ar_hs) begin
            r_addr <= s_axi.s_axi_araddr[ADDR_W-1:2];
            r_len  <= s_axi.s_axi_arlen;
            r_beat <= '0;
            r_dat  <= rd_mux;
            r_last <= (s_axi.s_axi_arlen == 8'd0);
        end else if (r_hs) begin
            if (r_last) begin
                r_last <= 1'b0;
            end else begin
                r_addr <= r_addr + WA_W'(1);
                r_beat <= r_beat + 8'd1;
                r_dat  <= rd_mux;
                r_last <= ((r_beat + 8'd1) == r_len);
            end
        end
    end

    // ---------------- PWM engine ----------------
    logic [15:0]      pre_cnt;
    logic [PWM_W-1:0] pwm_cnt;
    logic             tick, wrap;

    assign tick = ctrl_en && (pre_cnt == presc);
    assign wrap = tick && (pwm_cnt == CNT_MAX);

    // shadow duties reach the comparator only at a period boundary so a period is never torn
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
            led_o   <= '0;
            for (int k = 0; k < NUM_CH; k++) duty_act[k] <= '0;
        end else begin
            if (!ctrl_en || tick) pre_cnt <= '0;
            else                  pre_cnt <= pre_cnt + 16'd1;

            if (!ctrl_en || wrap) pwm_cnt <= '0;
            else if (tick)        pwm_cnt <= pwm_cnt + PWM_W'(1);

            for (int k = 0; k < NUM_CH; k++) begin
                if (!ctrl_en || wrap) duty_act[k] <= duty_sh[k];
                led_o[k] <= ctrl_en && (pwm_cnt < duty_act[k]);
            end
        end
    end

    assign s_axi.s_axi_awready = awready;
    assign s_axi.s_axi_wready  = wready;
    assign s_axi.s_axi_bvalid  = bvalid;
    assign s_axi.s_axi_bresp   = 2'b00;
    assign s_axi.s_axi_arready = arready;
    assign s_axi.s_axi_rvalid  = rvalid;
    assign s_axi.s_axi_rdata   = r_dat;
    assign s_axi.s_axi_rlast   = r_last;
    assign s_axi.s_axi_rresp   = 2'b00;

    logic unused_bits;
    assign unused_bits = ^{s_axi.s_axi_awaddr[1:0], s_axi.s_axi_araddr[1:0],
                           s_axi.s_axi_wdata[31:24], s_axi.s_axi_wstrb[3], s_axi.s_axi_wlast};

endmodule
